// File: rtl/matinv2.sv
// matinv2: 2x2 signed fixed-point matrix inverse.
// The reciprocal of det comes from a serial restoring divider; the four
// products are then formed one per clock.
// Optional macro MATINV2_SAT_EN: when defined, out-of-range reciprocals and
// products clamp to the signed DATA_WIDTH limits; when undefined they wrap.
module matinv2 #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BIN_POS    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [4*DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]     det,
    output logic                      ready,
    output logic                      complete,
    output logic                      singular,
    output logic [4*DATA_WIDTH-1:0]   inv
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned QW = 2 * BIN_POS + 1;   // quotient bits, one per divide edge
    localparam int unsigned RW = DW + 1;            // shifted partial remainder
    localparam int unsigned CW = $clog2(QW + 1);    // divide edge counter
    localparam int unsigned PW = 2 * DW;            // full product width

    localparam logic [DW-1:0]        WMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        WMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [PW-1:0] PMAX = {{(PW-DW){1'b0}}, WMAX};
    localparam logic signed [PW-1:0] PMIN = {{(PW-DW){1'b1}}, WMIN};

    typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

    state_t          state, state_nxt;
    logic [4*DW-1:0] a_q, a_nxt;
    logic [DW-1:0]   det_q, det_nxt;
    logic [DW-1:0]   rem_q, rem_nxt;
    logic [QW-1:0]   quo_q, quo_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [1:0]      idx_q, idx_nxt;
    logic            ready_nxt, complete_nxt, singular_nxt;
    logic [4*DW-1:0] inv_nxt;

    // Reduce a wide signed value to DW bits (clamp or wrap).
    function automatic logic [DW-1:0] reduce(input logic signed [PW-1:0] x);
`ifdef MATINV2_SAT_EN
        if (x > PMAX)      return WMAX;
        else if (x < PMIN) return WMIN;
        else               return x[DW-1:0];
`else
        return x[DW-1:0];
`endif
    endfunction

    // Negate, mapping the most-negative value to the most-positive one.
    function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] x);
        return (x == WMIN) ? WMAX : DW'(-x);
    endfunction

    // Divider step: shift in the next dividend bit (only the first is 1).
    logic [DW-1:0] det_abs;
    logic [RW-1:0] rem_sh;
    logic          rem_ge;
    logic [DW-1:0] rem_sub;
    logic [DW-1:0] rem_div;
    logic [QW-1:0] quo_div;

    assign det_abs = det_q[DW-1] ? DW'(-det_q) : det_q;
    assign rem_sh  = {rem_q, (cnt_q == CW'(0))};
    assign rem_ge  = rem_sh >= {1'b0, det_abs};
    assign rem_sub = rem_sh[DW-1:0] - det_abs;
    assign rem_div = rem_ge ? rem_sub : rem_sh[DW-1:0];
    assign quo_div = {quo_q[QW-2:0], rem_ge};

    // Signed reciprocal from the truncated quotient.
    logic signed [QW:0]   quo_s;
    logic signed [QW:0]   r_full;
    logic [DW-1:0]        r;

    assign quo_s  = {1'b0, quo_q};
    assign r_full = det_q[DW-1] ? -quo_s : quo_s;
    assign r      = reduce(PW'(r_full));

    // Current product operand and scaled result.
    logic [DW-1:0]        opnd;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic [DW-1:0]        elem;

    always_comb begin
        opnd = a_q[3*DW +: DW];
        case (idx_q)
            2'd0:    opnd = a_q[3*DW +: DW];
            2'd1:    opnd = neg_sat(a_q[1*DW +: DW]);
            2'd2:    opnd = neg_sat(a_q[2*DW +: DW]);
            default: opnd = a_q[0 +: DW];
        endcase
    end

    assign prod    = PW'($signed(r)) * PW'($signed(opnd));
    assign prod_sh = prod >>> BIN_POS;
    assign elem    = reduce(prod_sh);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            det_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            ready    <= 1'b1;
            complete <= 1'b0;
            singular <= 1'b0;
            inv      <= '0;
        end else begin
            state    <= state_nxt;
            a_q      <= a_nxt;
            det_q    <= det_nxt;
            rem_q    <= rem_nxt;
            quo_q    <= quo_nxt;
            cnt_q    <= cnt_nxt;
            idx_q    <= idx_nxt;
            ready    <= ready_nxt;
            complete <= complete_nxt;
            singular <= singular_nxt;
            inv      <= inv_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = DIV;
            DIV: begin
                if (det_q == '0)                   state_nxt = DONE;
                else if (cnt_q == CW'(QW - 1))     state_nxt = MUL;
            end
            MUL:        if (idx_q == 2'd3) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        a_nxt        = a_q;
        det_nxt      = det_q;
        rem_nxt      = rem_q;
        quo_nxt      = quo_q;
        cnt_nxt      = cnt_q;
        idx_nxt      = idx_q;
        complete_nxt = complete;
        singular_nxt = singular;
        inv_nxt      = inv;
        ready_nxt    = (state_nxt == IDLE) || (state_nxt == DONE);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_nxt        = a;
                    det_nxt      = det;
                    rem_nxt      = '0;
                    quo_nxt      = '0;
                    cnt_nxt      = '0;
                    idx_nxt      = '0;
                    complete_nxt = 1'b0;
                    singular_nxt = 1'b0;
                end
            end
            DIV: begin
                if (det_q == '0) begin
                    singular_nxt = 1'b1;
                    complete_nxt = 1'b1;
                    inv_nxt      = '0;
                end else begin
                    rem_nxt = rem_div;
                    quo_nxt = quo_div;
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            MUL: begin
                case (idx_q)
                    2'd0:    inv_nxt[0*DW +: DW] = elem;
                    2'd1:    inv_nxt[1*DW +: DW] = elem;
                    2'd2:    inv_nxt[2*DW +: DW] = elem;
                    default: inv_nxt[3*DW +: DW] = elem;
                endcase
                idx_nxt = idx_q + 2'd1;
                if (idx_q == 2'd3) complete_nxt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matinv2.sv
// Scoreboard bench for matinv2 (DATA_WIDTH=16, BIN_POS=8).
module tb_matinv2;

    localparam int DW = 16;
    localparam int BP = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [4*DW-1:0] a;
    logic [DW-1:0]   det;
    logic            ready;
    logic            complete;
    logic            singular;
    logic [4*DW-1:0] inv;

    always #5 clk = ~clk;

    matinv2 #(.DATA_WIDTH(DW), .BIN_POS(BP)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .det(det),
        .ready(ready), .complete(complete), .singular(singular), .inv(inv)
    );

    typedef struct {
        logic [4*DW-1:0] inv;
        logic            sing;
        int              edge_no;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic comp_d = 1'b0;

    // Pack words m00..m11 in port order.
    function automatic logic [4*DW-1:0] pk(int m0, int m1, int m2, int m3);
        return {16'(m3), 16'(m2), 16'(m1), 16'(m0)};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edge counter: after the Nth rising edge cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: on each rising complete pop the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && complete && !comp_d) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_complete: got complete=1 expected none at edge %0d", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_inv"}, 64'(inv), 64'(e.inv));
                check({e.name, "_singular"}, 64'(singular), 64'(e.sing));
                check({e.name, "_edge"}, 64'(cyc), 64'(e.edge_no));
            end
            done_cnt++;
        end
        comp_d = complete;
    end

    // Issue one inversion; optionally pulse start again while busy.
    task automatic run(string name, logic [4*DW-1:0] av, int dv,
                       logic [4*DW-1:0] ei, logic es, bit poke);
        exp_t e;
        int   target;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        det   = 16'(dv);
        e.inv     = ei;
        e.sing    = es;
        e.edge_no = cyc + (es ? 2 : 2 * BP + 6);
        e.name    = name;
        sb.push_back(e);
        target = done_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        a     = 64'hDEAD_BEEF_1234_5678;
        det   = 16'h7777;
        check({name, "_busy_ready"}, 64'(ready), 64'd0);
        if (poke) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            a     = pk(100, 200, 300, 400);
            det   = 16'd5;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 60; i++) begin
            if (done_cnt >= target) break;
            @(posedge clk);
        end
        if (done_cnt < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no complete expected complete within 60 cycles", name);
            sb.delete();
        end
        @(negedge clk);
        check({name, "_done_ready"}, 64'(ready), 64'd1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        det   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_complete", 64'(complete), 64'd0);
        check("rst_singular", 64'(singular), 64'd0);
        check("rst_inv", 64'(inv), 64'd0);
        rst = 1'b0;

        run("identity", pk(256, 0, 0, 256), 256, pk(256, 0, 0, 256), 1'b0, 1'b0);

        run("diagonal", pk(512, 0, 0, 1024), 2048, pk(128, 0, 0, 64), 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("hold_complete", 64'(complete), 64'd1);
        check("hold_inv", 64'(inv), 64'(pk(128, 0, 0, 64)));

        run("negdet", pk(0, 256, 256, 0), -256, pk(0, 256, 256, 0), 1'b0, 1'b0);
        run("general", pk(256, 512, 768, 1024), -512, pk(-512, 256, 384, -128), 1'b0, 1'b0);
        run("trunc", pk(768, 0, 0, 768), 768, pk(255, 0, 0, 255), 1'b0, 1'b0);
        run("singular", pk(256, 512, 512, 1024), 0, '0, 1'b1, 1'b0);
        run("singular2", pk(1, 2, 3, 4), 0, '0, 1'b1, 1'b0);
        run("minneg", pk(0, -32768, -32768, 0), 256, pk(0, 32767, 32767, 0), 1'b0, 1'b0);
        run("mindet", pk(256, 0, 0, 256), -32768, pk(-2, 0, 0, -2), 1'b0, 1'b0);
        run("busy_ignore", pk(256, 0, 0, 256), 256, pk(256, 0, 0, 256), 1'b0, 1'b1);
`ifdef MATINV2_SAT_EN
        run("recip_ovf", pk(256, 0, 0, 256), 1, pk(32767, 0, 0, 32767), 1'b0, 1'b0);
        run("prod_ovf", pk(0, 0, 0, 32767), 128, pk(32767, 0, 0, 0), 1'b0, 1'b0);
`else
        run("recip_ovf", pk(256, 0, 0, 256), 1, pk(0, 0, 0, 0), 1'b0, 1'b0);
        run("prod_ovf", pk(0, 0, 0, 32767), 128, pk(-2, 0, 0, 0), 1'b0, 1'b0);
`endif

        // Reset sampled on edge 6 of a run aborts it.
        @(negedge clk);
        start = 1'b1;
        a     = pk(256, 0, 0, 256);
        det   = 16'd256;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_complete", 64'(complete), 64'd0);
        check("midrst_inv", 64'(inv), 64'd0);
        rst = 1'b0;
        run("post_rst", pk(256, 0, 0, 256), 256, pk(256, 0, 0, 256), 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matinv2.md
MATINV2 -- requirements
Module: matinv2

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 16, meaning the signed two's-complement fixed-point word width.
REQ-002 The block SHALL take parameter BIN_POS, default 8, meaning the number of fraction bits; BIN_POS < DATA_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to invert; sampled only while ready=1.
REQ-006 The block SHALL have port a, input, 4*DATA_WIDTH bits: the 2x2 matrix, word k at bits [k*DATA_WIDTH +: DATA_WIDTH], order m00, m01, m10, m11.
REQ-007 The block SHALL have port det, input, DATA_WIDTH bits: the determinant m00*m11 - m01*m10 produced by the upstream determinant stage.
REQ-008 The block SHALL have port ready, output, 1 bit: high when a new start can be accepted.
REQ-009 The block SHALL have port complete, output, 1 bit: high when inv and singular are valid.
REQ-010 The block SHALL have port singular, output, 1 bit: high when the latched det was zero.
REQ-011 The block SHALL have port inv, output, 4*DATA_WIDTH bits: the inverse matrix, packed in the same word order as a.

Function
REQ-012 The block SHALL implement the states IDLE, DIV, MUL and DONE; ready=1 in IDLE and DONE only.
REQ-013 On an edge with ready=1 and start=1, the block SHALL latch a and det, clear complete and singular, and go to DIV; if the latched det=0 it SHALL instead go to DONE with singular=1 and inv=0.
REQ-014 In DIV the block SHALL run an unsigned restoring divide of 2^(2*BIN_POS) by |det|, one quotient bit per edge, for exactly 2*BIN_POS+1 edges.
REQ-015 The reciprocal r SHALL be the truncated quotient, negated when det<0.
REQ-016 In MUL the block SHALL compute one element per edge, in order inv0=r*m11, inv1=r*(-m01), inv2=r*(-m10), inv3=r*m00.
REQ-017 Each product SHALL be formed at 2*DATA_WIDTH bits, arithmetically shifted right by BIN_POS, then reduced to DATA_WIDTH bits under the REQ-025 rules.
REQ-018 Negating the most-negative input SHALL yield 2^(DATA_WIDTH-1)-1.
REQ-019 On the last MUL edge the block SHALL set complete=1 and enter DONE; with the start edge counted as edge 1, complete rises on edge 2*BIN_POS+6, or on edge 2 for a singular det.
REQ-020 In DONE, complete, singular and inv SHALL hold until the next accepted start or rst.
REQ-021 The block SHALL ignore start while ready=0; changes on a and det after the start edge SHALL have no effect.

Reset
REQ-022 rst SHALL take priority over start, including mid-DIV or mid-MUL.
REQ-023 On reset the block SHALL enter IDLE with ready=1, complete=0, singular=0, inv=0, and clear all internal divider and counter registers.

Configuration
REQ-024 The macro MATINV2_SAT_EN SHALL select the overflow behaviour of the reciprocal and the products.
REQ-025 With MATINV2_SAT_EN defined, a reciprocal or product outside the signed DATA_WIDTH range SHALL clamp to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1); without it, the value SHALL wrap by keeping the low DATA_WIDTH bits.

Verification (DATA_WIDTH=16, BIN_POS=8)
REQ-026 Identity: a={256,0,0,256}, det=256, start -> inv={256,0,0,256}, singular=0, complete rises on edge 22.
REQ-027 Diagonal: a={512,0,0,1024}, det=2048 -> r=32, inv={128,0,0,64}.
REQ-028 Negative det: a={0,256,256,0}, det=-256 -> r=-256, inv={0,256,256,0}.
REQ-029 Singular and busy: det=0 -> complete=1 and singular=1 on edge 2 with inv=0; a start pulse during DIV of a later run -> ignored.
REQ-030 Overflow: det=1 -> r=32767 with MATINV2_SAT_EN defined, r=0 without it.
REQ-031 Reset mid-DIV: rst asserted on edge 6 -> ready=1 and complete=0 on the next edge; a fresh identity run afterwards -> inv={256,0,0,256}.
